// File: rtl/seq_divider_ctrl.sv
// Sequential restoring divider: one trial subtraction per clock on an N+1 bit
// add/subtract unit, with a start/done handshake toward the control unit.

module add_subs #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         add_sub,
  output logic [W-1:0] res,
  output logic         cout
);
  logic [W-1:0] b_x;

  // Two's-complement add/subtract; cout=1 in subtract mode means no borrow
  always_comb begin
    b_x         = add_sub ? ~b : b;
    {cout, res} = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, add_sub};
  end
endmodule

module seq_divider_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N:0]    p_q, p_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic [N:0]    s_s, diff_s;
  logic          no_borrow_s;

  assign s_s = {p_q[N-1:0], q_q[N-1]};

  add_subs #(.W(N + 1)) u_add_subs (
    .a       (s_s),
    .b       ({1'b0, d_q}),
    .add_sub (1'b1),
    .res     (diff_s),
    .cout    (no_borrow_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (divisor != {N{1'b0}}) ? ST_RUN : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next values; results only update on the last iteration or a divide by zero
  always_comb begin
    p_d    = p_q;
    q_d    = q_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (divisor != {N{1'b0}})) begin
          p_d   = {(N + 1){1'b0}};
          q_d   = dividend;
          d_d   = divisor;
          cnt_d = CW'(N - 1);
          dbz_d = 1'b0;
        end else if (start) begin
          quot_d = {N{1'b1}};
          rem_d  = dividend;
          dbz_d  = 1'b1;
        end else begin
          p_d = p_q;
        end
      end
      ST_RUN: begin
        if (no_borrow_s) begin
          p_d = diff_s;
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          p_d = s_s;
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == {CW{1'b0}}) begin
          quot_d = q_d;
          rem_d  = p_d[N-1:0];
        end else begin
          quot_d = quot_q;
        end
      end
      default: begin
        p_d = p_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q    <= {(N + 1){1'b0}};
      q_q    <= {N{1'b0}};
      d_q    <= {N{1'b0}};
      cnt_q  <= {CW{1'b0}};
      quot_q <= {N{1'b0}};
      rem_q  <= {N{1'b0}};
      dbz_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      q_q    <= q_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Scoreboard bench for seq_divider_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done pulses.

module tb_seq_divider_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, dbz;
  logic [N-1:0] quotient, remainder;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seq_divider_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", {24'd0, quotient}, {24'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("dbz", {31'd0, dbz}, {31'd0, e.z});
      end
    end
  end

  // Issue one division in the current cycle and check the busy/done timeline
  task automatic run_div(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    logic [N-1:0] held_q;
    held_q   = quotient;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    sb.push_back('{q: eq, r: er, z: ez});
    tick();
    start = 1'b0;
    if (dvs == '0) begin
      chk("dbz_busy_c1", {31'd0, busy}, 32'd0);
      chk("dbz_done_c1", {31'd0, done}, 32'd1);
    end else begin
      for (int k = 1; k <= N; k++) begin
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_no_done", {31'd0, done}, 32'd0);
        chk("run_quot_held", {24'd0, quotient}, {24'd0, held_q});
        tick();
      end
      chk("done_at_c_n1", {31'd0, done}, 32'd1);
      chk("busy_low_done", {31'd0, busy}, 32'd0);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset for two cycles
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", {24'd0, quotient}, 32'd0);
    chk("rst_rem", {24'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_no_done", {31'd0, done}, 32'd0);
      chk("idle_no_busy", {31'd0, busy}, 32'd0);
    end

    run_div(8'd200, 8'd7,   8'd28,  8'd4,  1'b0);
    run_div(8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
    run_div(8'd5,   8'd9,   8'd0,   8'd5,  1'b0);
    run_div(8'd255, 8'd255, 8'd1,   8'd0,  1'b0);
    run_div(8'd128, 8'd2,   8'd64,  8'd0,  1'b0);
    run_div(8'd77,  8'd0,   8'd255, 8'd77, 1'b1);
    run_div(8'd10,  8'd3,   8'd3,   8'd1,  1'b0);

    // Start during RUN is ignored
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd3;
    sb.push_back('{q: 8'd33, r: 8'd1, z: 1'b0});
    tick();
    start = 1'b0;
    tick();
    tick();
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("ign_done_c9", {31'd0, done}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold_quot", {24'd0, quotient}, 32'd33);
      chk("hold_rem", {24'd0, remainder}, 32'd1);
      chk("hold_dbz", {31'd0, dbz}, 32'd0);
      chk("hold_no_done", {31'd0, done}, 32'd0);
      tick();
    end

    // Reset mid-operation
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_quot", {24'd0, quotient}, 32'd0);
    chk("mid_rst_rem", {24'd0, remainder}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_rst_no_done", {31'd0, done}, 32'd0);
    end
    run_div(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

    tick();
    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_divider_ctrl.md
Name: seq_divider_ctrl

Overview:
- Sequential restoring-division controller for unsigned operands of width N.
- Owns and sequences one add_subs instance of width N+1, held permanently in subtract mode (add_sub=1).
- Runs one trial subtraction per cycle, using cout as the no-borrow flag.
- Serves as the DIV helper unit beside the ALU, with a start/done handshake to the control unit.

Parameters:
- N, 8, operand, quotient and remainder width (N >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  N  unsigned dividend; captured when start is accepted.
- divisor  input  N  unsigned divisor; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid in that cycle.
- quotient  output  N  registered quotient.
- remainder  output  N  registered remainder.
- dbz  output  1  divide-by-zero flag for the last operation.

Behaviour:
- Reset: one clock, one reset. Reset is synchronous and active-low: rst_n low at a clk rising edge forces the following, from any state and including mid-operation:
  - state=IDLE, busy=0, done=0, quotient=0, remainder=0, dbz=0;
  - internal partial remainder P (N+1 bits), shift register Q (N bits), divisor register D (N bits) and counter cnt all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and divisor!=0: load P=0, Q=dividend, D=divisor, cnt=N-1, dbz<=0, go to RUN.
  - start=1 and divisor==0: go to DONE directly with quotient<={N{1'b1}}, remainder<=dividend, dbz<=1.
  - start=0: stay in IDLE.
- RUN (busy=1), one iteration per clock:
  - S = {P[N-1:0], Q[N-1]} (N+1 bits) is the add_subs input a.
  - {1'b0, D} is the add_subs input b.
  - cout=1 (no borrow): P<=res, Q<={Q[N-2:0],1'b1}.
  - cout=0: P<=S (restore), Q<={Q[N-2:0],1'b0}.
  - cnt decrements each iteration.
  - Iteration with cnt==0: also writes quotient<=next Q and remainder<=next P[N-1:0], then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE unconditionally.
- Latency:
  - start high in cycle c (divisor!=0): busy high in cycles c+1..c+N, done high in cycle c+N+1.
  - Divide by zero: done high in cycle c+1, busy never asserted.
- Output holding: quotient, remainder and dbz are held from DONE until the next accepted start's completion. They do not change during RUN.
- start while in RUN or DONE is ignored and not queued. Operand inputs are don't-care outside the accept cycle.
- Width rules:
  - The add_subs is internal and fixed in subtract mode.
  - The MSB of P is always 0 after each iteration.
  - Results are exact unsigned floor division: dividend = quotient*divisor + remainder, with remainder < divisor.
- Back-to-back: start may be reasserted in the IDLE cycle following DONE. Minimum issue interval is N+2 cycles.

Test Plan:
- Reset release, N=8: assert rst_n=0 for 2 cycles -> all outputs 0, state IDLE; start=0 for 5 cycles -> done never pulses.
- 200/7 -> quotient=28, remainder=4, dbz=0, done in cycle c+9, busy high in c+1..c+8; 255/1 -> quotient=255, remainder=0.
- 5/9 -> quotient=0, remainder=5; 255/255 -> quotient=1, remainder=0; 128/2 -> quotient=64, remainder=0.
- 77/0 -> done in cycle c+1, quotient=255, remainder=77, dbz=1, busy=0 throughout. A following 10/3 -> quotient=3, remainder=1, dbz=0.
- Start 100/3, pulse start again with 9/9 at cycle c+3 -> second request ignored; result quotient=33, remainder=1 at c+9. Outputs held stable across 3 idle cycles.
- Start 200/7, drive rst_n=0 at cycle c+4 -> next cycle IDLE, busy=0, quotient=remainder=0, no done pulse. Restart 50/6 -> quotient=8, remainder=2.
